int_ram_pingpong_ctrl: RTL and testbench
========================================

Name: int_ram_pingpong_ctrl

Overview:
- Ping-pong controller for the two-bank intrinsic-message RAM. Bank i is driven by port index i.
- A loader streams channel LLRs of one codeword into the fill bank. Meanwhile the decoder reads the previous codeword from the other bank.
- Owns all address, cs, we and data_in for both banks, and routes read data back to the decoder.
- Sits between the channel input interface and the LDPC decoder core.

Parameters:
- DATA_WIDTH, 5, width of one intrinsic LLR word.
- ADDR_WIDTH, 8, bank address width.
- CODE_LEN, 256, words per codeword. Legal range is 2 to 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  loader word valid.
- in_data  in  DATA_WIDTH  loader LLR.
- in_ready  out  1  controller accepts a word this cycle.
- dec_start  out  1  one-cycle pulse: a full bank is owned by the decoder.
- dec_busy  out  1  high while the decoder owns a bank.
- dec_rd_en  in  1  decoder read request.
- dec_rd_addr  in  ADDR_WIDTH  decoder read address.
- dec_rd_valid  out  1  read data valid.
- dec_rd_data  out  DATA_WIDTH  read data.
- dec_done  in  1  pulse: decoder finished with its bank.
- bank_full  out  2  per-bank full flag.
- ram_address  out  ADDR_WIDTH [0:1]  to RAM address.
- ram_data_in  out  DATA_WIDTH [0:1]  to RAM data_in.
- ram_we  out  1 [0:1]  to RAM we.
- ram_cs  out  1 [0:1]  to RAM cs.
- ram_data_out  in  DATA_WIDTH [0:1]  from RAM data_out.

Behaviour:
- Internal state: fill_sel (1b), dec_sel (1b), bank_full[1:0], wr_cnt (ADDR_WIDTH), decoder FSM {D_IDLE, D_BUSY}, and a 2-stage read-valid/bank-select pipeline.
- Reset values, all zero: fill_sel, dec_sel, bank_full, wr_cnt, FSM=D_IDLE, dec_start, dec_busy, dec_rd_valid, all ram_* outputs.
- Reset applies immediately and asynchronously at any time. A partially loaded or in-decode codeword is discarded.
- in_ready = !bank_full[fill_sel], combinational from registers. It is 0 while reset is asserted.
- Write path, on an accepted word (in_valid && in_ready) at edge t:
  - registers ram_cs[fill_sel]=1, ram_we[fill_sel]=1, ram_address[fill_sel]=wr_cnt, ram_data_in[fill_sel]=in_data;
  - the RAM writes at edge t+1;
  - with no accept, ram_we and ram_cs for the fill bank return to 0 the next cycle.
- Write counter: wr_cnt increments on each accept. When the accepted word is at wr_cnt==CODE_LEN-1:
  - bank_full[fill_sel] is set;
  - wr_cnt wraps to 0;
  - fill_sel toggles.
- If the new fill bank is still full, in_ready stays 0 (loader stalls) until that bank is freed.
- Decoder FSM:
  - D_IDLE: if bank_full[dec_sel], go to D_BUSY, pulse dec_start for exactly one cycle, and set dec_busy=1.
  - D_BUSY: each dec_rd_en at edge t registers ram_cs[dec_sel]=1, ram_we[dec_sel]=0 and ram_address[dec_sel]=dec_rd_addr.
  - Read return: dec_rd_valid=1 in the cycle after edge t+1, i.e. fixed 2-cycle latency. dec_rd_data is ram_data_out[bank captured with the request]. Back-to-back reads give one word per cycle.
  - D_BUSY on dec_done: clear bank_full[dec_sel], toggle dec_sel, dec_busy=0, go to D_IDLE.
- Earliest next dec_start is the cycle after D_IDLE is re-entered.
- Reads in flight when dec_done arrives still return from the old bank.
- dec_rd_en outside D_BUSY is ignored (no RAM access, no valid).
- dec_done outside D_BUSY is ignored.
- No bounds check on dec_rd_addr.
- Bank conflict is impossible by construction: the fill bank is never full, and the decoder bank is always full. Each bank sees at most one requester per cycle.
- Simultaneous events:
  - the last-word fill of one bank and dec_done on the other bank in the same cycle both take effect;
  - a bank freed by dec_done makes in_ready rise the following cycle if that bank is fill_sel.
- dec_start may not be issued before the final write of the bank has landed. Guaranteed because bank_full is set at edge t, dec_start is seen at t+1, and the earliest read reaches the RAM at t+2 or later.

Test Plan (CODE_LEN=4 override unless noted):
- Reset, then stream 4 words 1,2,3,4 with in_valid held high:
  - in_ready=1 for 4 accepts;
  - bank 0 gets addresses 0..3 = 1..4;
  - bank_full=01;
  - dec_start pulses once, 2 cycles after the last accept;
  - fill_sel=1.
- After the above, reads of addresses 0..3 back-to-back: dec_rd_valid high for 4 consecutive cycles starting 2 cycles after the first dec_rd_en, data 1,2,3,4.
- Load 8 words with the decoder never asserting dec_done:
  - both banks full, bank_full=11;
  - in_ready=0 and a 9th word is held;
  - then dec_done makes in_ready=1 next cycle, the 9th word is written to bank 0 address 0, and the next dec_start targets bank 1.
- Same-cycle event: last-word accept into bank 1 coincides with dec_done for bank 0. Required: bank_full goes 01→10, then dec_start for bank 1 next cycle.
- Assert reset mid-load after 2 words and mid-read: all outputs 0 immediately, bank_full=00, and the next load starts at bank 0 address 0.
- dec_rd_en and dec_done pulsed in D_IDLE: no ram_cs, no dec_rd_valid, no state change.

Source files
------------

// File: rtl/int_ram_pingpong_ctrl.sv
// Ping-pong controller for the two-bank intrinsic-message RAM: the loader fills one bank
// while the decoder reads the other, and the roles swap when a bank is full and released.
module int_ram_pingpong_ctrl #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int CODE_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  dec_start,
    output logic                  dec_busy,
    input  logic                  dec_rd_en,
    input  logic [ADDR_WIDTH-1:0] dec_rd_addr,
    output logic                  dec_rd_valid,
    output logic [DATA_WIDTH-1:0] dec_rd_data,
    input  logic                  dec_done,
    output logic [1:0]            bank_full,
    output logic [ADDR_WIDTH-1:0] ram_address  [0:1],
    output logic [DATA_WIDTH-1:0] ram_data_in  [0:1],
    output logic                  ram_we       [0:1],
    output logic                  ram_cs       [0:1],
    input  logic [DATA_WIDTH-1:0] ram_data_out [0:1]
);

    typedef enum logic {D_IDLE, D_BUSY} dstate_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CODE_LEN - 1);

    dstate_t               state, state_nxt;
    logic                  fill_sel, dec_sel;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [1:0]            bank_full_nxt;
    logic                  accept, last_word;
    logic                  start_go, rd_go, done_go;
    logic                  rd_v1, rd_s1, rd_s2;

    // in_ready is forced low while reset is held, not just after the registers clear
    assign in_ready  = reset && !bank_full[fill_sel];
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (wr_cnt == LAST_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE: if (bank_full[dec_sel]) state_nxt = D_BUSY;
            D_BUSY: if (dec_done)           state_nxt = D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
    end

    always_comb begin
        dec_busy = (state == D_BUSY);
        start_go = (state == D_IDLE) && bank_full[dec_sel];
        rd_go    = (state == D_BUSY) && dec_rd_en;
        done_go  = (state == D_BUSY) && dec_done;
    end

    // Release of the decoder bank and completion of the fill bank always touch different bits
    always_comb begin
        bank_full_nxt = bank_full;
        if (done_go)   bank_full_nxt[dec_sel]  = 1'b0;
        if (last_word) bank_full_nxt[fill_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_sel  <= 1'b0;
            dec_sel   <= 1'b0;
            bank_full <= '0;
            wr_cnt    <= '0;
            dec_start <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            dec_start <= start_go;
            if (done_go) dec_sel <= ~dec_sel;
            if (accept) begin
                if (last_word) begin
                    wr_cnt   <= '0;
                    fill_sel <= ~fill_sel;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // Fill bank and decoder bank never coincide while both are active, so one requester per bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                ram_address[b] <= '0;
                ram_data_in[b] <= '0;
                ram_we[b]      <= 1'b0;
                ram_cs[b]      <= 1'b0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (accept && (fill_sel == 1'(b))) begin
                    ram_cs[b]      <= 1'b1;
                    ram_we[b]      <= 1'b1;
                    ram_address[b] <= wr_cnt;
                    ram_data_in[b] <= in_data;
                end else if (rd_go && (dec_sel == 1'(b))) begin
                    ram_cs[b]      <= 1'b1;
                    ram_we[b]      <= 1'b0;
                    ram_address[b] <= dec_rd_addr;
                end else begin
                    ram_cs[b] <= 1'b0;
                    ram_we[b] <= 1'b0;
                end
            end
        end
    end

    // Bank select travels with the request so reads in flight at dec_done use the old bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_v1        <= 1'b0;
            rd_s1        <= 1'b0;
            rd_s2        <= 1'b0;
            dec_rd_valid <= 1'b0;
        end else begin
            rd_v1        <= rd_go;
            rd_s1        <= dec_sel;
            rd_s2        <= rd_s1;
            dec_rd_valid <= rd_v1;
        end
    end

    assign dec_rd_data = ram_data_out[rd_s2];

endmodule

// File: tb/tb_int_ram_pingpong_ctrl.sv
// Bench for int_ram_pingpong_ctrl with CODE_LEN=4: codeword-queue reference model,
// two-bank RAM model, and a read-return scoreboard.
module tb_int_ram_pingpong_ctrl;

    localparam int DW = 5;
    localparam int AW = 8;
    localparam int CL = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          dec_start;
    logic          dec_busy;
    logic          dec_rd_en;
    logic [AW-1:0] dec_rd_addr;
    logic          dec_rd_valid;
    logic [DW-1:0] dec_rd_data;
    logic          dec_done;
    logic [1:0]    bank_full;
    logic [AW-1:0] ram_address  [0:1];
    logic [DW-1:0] ram_data_in  [0:1];
    logic          ram_we       [0:1];
    logic          ram_cs       [0:1];
    logic [DW-1:0] ram_data_out [0:1];

    int_ram_pingpong_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CODE_LEN  (CL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .dec_start   (dec_start),
        .dec_busy    (dec_busy),
        .dec_rd_en   (dec_rd_en),
        .dec_rd_addr (dec_rd_addr),
        .dec_rd_valid(dec_rd_valid),
        .dec_rd_data (dec_rd_data),
        .dec_done    (dec_done),
        .bank_full   (bank_full),
        .ram_address (ram_address),
        .ram_data_in (ram_data_in),
        .ram_we      (ram_we),
        .ram_cs      (ram_cs),
        .ram_data_out(ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM per bank
    logic [DW-1:0] mem [2][256];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (ram_cs[b]) begin
                if (ram_we[b]) mem[b][ram_address[b]] <= ram_data_in[b];
                else           ram_data_out[b] <= mem[b][ram_address[b]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: completed codewords awaiting release, oldest owned by the decoder
    typedef logic [DW-1:0] cw_t [CL];
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    cw_t           cw_q[$];
    logic [DW-1:0] cur[$];
    rd_t           exp_q[$];
    int            ncw = 0;
    bit            m_busy = 0;

    function automatic logic [1:0] bf_model();
        logic [1:0] bf = '0;
        for (int i = 0; i < cw_q.size(); i++) bf[(ncw - cw_q.size() + i) % 2] = 1'b1;
        return bf;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            rd_t e;
            if (dec_rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", 32'(dec_rd_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_latency", 32'(cyc), 32'(e.due));
                    chk("rd_data", 32'(dec_rd_data), 32'(e.data));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("rd_missing", 32'(dec_rd_valid), 32'd1);
            end
        end
    end

    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit rd,
                         input logic [AW-1:0] a, input bit dn);
        bit   acc, busy_pre, start_exp, ew, er;
        int   fb, ob, wi;
        cw_t  tmp;
        in_valid = v; in_data = d; dec_rd_en = rd; dec_rd_addr = a; dec_done = dn;
        acc      = v && (cw_q.size() < 2);
        fb       = ncw % 2;
        ob       = (ncw - cw_q.size()) % 2;
        wi       = cur.size();
        busy_pre = m_busy;
        if (rd && busy_pre) exp_q.push_back('{cw_q[0][int'(a)], cyc + 2});
        @(posedge clk); #1;
        start_exp = 0;
        if (busy_pre && dn) begin
            void'(cw_q.pop_front());
            m_busy = 0;
        end else if (!busy_pre && cw_q.size() > 0) begin
            m_busy    = 1;
            start_exp = 1;
        end
        if (acc) begin
            cur.push_back(d);
            if (cur.size() == CL) begin
                for (int i = 0; i < CL; i++) tmp[i] = cur[i];
                cw_q.push_back(tmp);
                ncw++;
                cur.delete();
            end
        end
        chk("in_ready", 32'(in_ready), 32'(cw_q.size() < 2));
        chk("bank_full", 32'(bank_full), 32'(bf_model()));
        chk("dec_busy", 32'(dec_busy), 32'(m_busy));
        chk("dec_start", 32'(dec_start), 32'(start_exp));
        for (int b = 0; b < 2; b++) begin
            ew = acc && (b == fb);
            er = rd && busy_pre && (b == ob);
            chk($sformatf("ram_cs%0d", b), 32'(ram_cs[b]), 32'(ew || er));
            chk($sformatf("ram_we%0d", b), 32'(ram_we[b]), 32'(ew));
            if (ew) begin
                chk($sformatf("wr_addr%0d", b), 32'(ram_address[b]), 32'(wi));
                chk($sformatf("wr_data%0d", b), 32'(ram_data_in[b]), 32'(d));
            end
            if (er) chk($sformatf("rd_addr%0d", b), 32'(ram_address[b]), 32'(a));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; dec_rd_en = 1'b0; dec_done = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_dec_start", 32'(dec_start), 32'd0);
        chk("rst_dec_busy", 32'(dec_busy), 32'd0);
        chk("rst_rd_valid", 32'(dec_rd_valid), 32'd0);
        for (int b = 0; b < 2; b++) begin
            chk("rst_ram_cs", 32'(ram_cs[b]), 32'd0);
            chk("rst_ram_we", 32'(ram_we[b]), 32'd0);
            chk("rst_ram_addr", 32'(ram_address[b]), 32'd0);
            chk("rst_ram_din", 32'(ram_data_in[b]), 32'd0);
        end
        cw_q.delete(); cur.delete(); exp_q.delete();
        ncw = 0; m_busy = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        dec_rd_en = 1'b0; dec_rd_addr = '0; dec_done = 1'b0;
        #2;
        do_reset();

        // First codeword into bank 0, then decoder start
        for (int i = 0; i < CL; i++) cycle(1'b1, DW'(i + 1), 1'b0, '0, 1'b0);
        idle(2);
        for (int i = 0; i < CL; i++) chk("bank0_content", 32'(mem[0][i]), 32'(i + 1));

        // Back-to-back reads of the owned bank
        for (int i = 0; i < CL; i++) cycle(1'b0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);

        // Fill bank 1 without release, then a stalled ninth word
        for (int i = 0; i < CL; i++) cycle(1'b1, DW'(i + 5), 1'b0, '0, 1'b0);
        repeat (3) cycle(1'b1, DW'(9), 1'b0, '0, 1'b0);
        chk("both_full", 32'(bank_full), 32'd3);
        cycle(1'b1, DW'(9), 1'b0, '0, 1'b1);
        cycle(1'b1, DW'(9), 1'b0, '0, 1'b0);
        idle(1);
        chk("ninth_word_bank0", 32'(mem[0][0]), 32'd9);
        for (int i = 0; i < CL; i++) cycle(1'b0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);

        // Last-word fill of bank 1 coinciding with release of bank 0
        do_reset();
        for (int i = 0; i < CL; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        idle(2);
        for (int i = 0; i < CL - 1; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b1);
        chk("same_cycle_full", 32'(bank_full), 32'd2);
        idle(1);
        chk("same_cycle_start", 32'(dec_start), 32'd1);
        for (int i = 0; i < CL; i++) cycle(1'b0, '0, 1'b1, AW'(i), 1'b0);
        idle(3);

        // Reset with reads in flight and bank 1 partially loaded
        do_reset();
        for (int i = 0; i < CL; i++) cycle(1'b1, DW'($urandom), 1'b0, '0, 1'b0);
        idle(2);
        cycle(1'b1, DW'(3), 1'b1, AW'(0), 1'b0);
        cycle(1'b1, DW'(4), 1'b1, AW'(1), 1'b0);
        do_reset();
        cycle(1'b1, DW'(7), 1'b0, '0, 1'b0);
        idle(1);
        chk("post_reset_bank0", 32'(mem[0][0]), 32'd7);

        // Decoder controls while idle must be ignored
        do_reset();
        repeat (2) cycle(1'b0, '0, 1'b1, AW'(2), 1'b1);
        idle(3);
        chk("idle_busy", 32'(dec_busy), 32'd0);

        // Randomized traffic
        do_reset();
        repeat (3000) begin
            cycle(($urandom % 10) < 7, DW'($urandom), 1'($urandom), AW'($urandom % CL),
                  ($urandom % 16) == 0);
        end
        idle(5);
        chk("reads_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
